// File: rtl/round_robin_arbiter_n_burst_if.sv
// Request/grant bundle for round_robin_arbiter_n_burst.
// Handshake: requests[i] is the valid from client i; grants[i] is its ready, sampled in the same cycle.
interface round_robin_arbiter_n_burst_if #(
    parameter int N_REQ = 4
);
    localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] requests;
    logic [N_REQ-1:0] grants;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;

    modport master (
        output requests,
        input  grants,
        input  grant_valid,
        input  grant_idx
    );

    modport slave (
        input  requests,
        output grants,
        output grant_valid,
        output grant_idx
    );
endinterface

// File: rtl/round_robin_arbiter_n_burst.sv
// N-requester round-robin arbiter with bounded burst hold.
// Define RR_ARB_REGISTERED_GRANTS_EN to register grants/grant_valid/grant_idx.
module round_robin_arbiter_n_burst #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    round_robin_arbiter_n_burst_if.slave  bus
);
    localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic [IW-1:0] TOP_IDX   = IW'(N_REQ - 1);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    last_idx;
    logic             last_valid;
    logic [CW-1:0]    cnt;

    logic             dec_valid;
    logic [IW-1:0]    dec_idx;
    logic [N_REQ-1:0] dec_grants;
    logic             hold;

    // Hold the current owner while its burst budget lasts, otherwise scan cyclically from ptr.
    always_comb begin
        int cand;
        cand       = 0;
        dec_valid  = 1'b0;
        dec_idx    = '0;
        hold       = last_valid && bus.requests[last_idx] && (cnt < BURST_MAX);
        if (hold) begin
            dec_valid = 1'b1;
            dec_idx   = last_idx;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= N_REQ) cand = cand - N_REQ;
                if (!dec_valid && bus.requests[IW'(cand)]) begin
                    dec_valid = 1'b1;
                    dec_idx   = IW'(cand);
                end
            end
        end
        dec_grants = '0;
        if (dec_valid) dec_grants[dec_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            last_idx   <= '0;
            last_valid <= 1'b0;
            cnt        <= '0;
        end else if (dec_valid) begin
            ptr        <= (dec_idx == TOP_IDX) ? '0 : dec_idx + 1'b1;
            last_idx   <= dec_idx;
            last_valid <= 1'b1;
            if (last_valid && dec_idx == last_idx)
                cnt <= (cnt == BURST_MAX) ? BURST_MAX : cnt + 1'b1;
            else
                cnt <= CW'(1);
        end else begin
            last_valid <= 1'b0;
            cnt        <= '0;
        end
    end

`ifdef RR_ARB_REGISTERED_GRANTS_EN
    logic [N_REQ-1:0] grants_q;
    logic             grant_valid_q;
    logic [IW-1:0]    grant_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            grants_q      <= dec_grants;
            grant_valid_q <= dec_valid;
            grant_idx_q   <= dec_idx;
        end
    end

    assign bus.grants      = grants_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
`else
    // Outputs are forced low during reset even though the decision path is combinational.
    assign bus.grants      = rst ? '0   : dec_grants;
    assign bus.grant_valid = rst ? 1'b0 : dec_valid;
    assign bus.grant_idx   = rst ? '0   : dec_idx;
`endif
endmodule

// File: tb/tb_round_robin_arbiter_n_burst.sv
// Directed bench for round_robin_arbiter_n_burst: 4x1, 4x3 (burst) and 3x1 instances.
module tb_round_robin_arbiter_n_burst;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_robin_arbiter_n_burst_if #(.N_REQ(4)) bus4 ();
  round_robin_arbiter_n_burst_if #(.N_REQ(4)) busb ();
  round_robin_arbiter_n_burst_if #(.N_REQ(3)) bus3 ();

  round_robin_arbiter_n_burst #(.N_REQ(4), .MAX_BURST(1)) u_arb4 (.clk(clk), .rst(rst), .bus(bus4));
  round_robin_arbiter_n_burst #(.N_REQ(4), .MAX_BURST(3)) u_arbb (.clk(clk), .rst(rst), .bus(busb));
  round_robin_arbiter_n_burst #(.N_REQ(3), .MAX_BURST(1)) u_arb3 (.clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q[$];  // {dut select, expected grant vector}

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int sel, output logic [3:0] g, output logic v, output logic [1:0] i);
    case (sel)
      0:       begin g = bus4.grants;          v = bus4.grant_valid; i = bus4.grant_idx; end
      1:       begin g = busb.grants;          v = busb.grant_valid; i = busb.grant_idx; end
      default: begin g = {1'b0, bus3.grants};  v = bus3.grant_valid; i = bus3.grant_idx; end
    endcase
  endtask

  task automatic check_pop(input string tag);
    logic [5:0] e;
    logic [3:0] eg, g;
    logic [1:0] ei, i;
    logic       v;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=empty_queue expected=entry", tag);
      return;
    end
    e  = exp_q.pop_front();
    eg = e[3:0];
    ei = 2'd0;
    for (int j = 0; j < 4; j++) if (eg[j]) ei = 2'(j);
    get_obs(int'(e[5:4]), g, v, i);
    check({tag, "_grants"}, g, eg);
    check({tag, "_valid"}, {3'b0, v}, {3'b0, |eg});
    check({tag, "_idx"}, {2'b0, i}, {2'b0, ei});
  endtask

  // Starts and ends at posedge+1; the decision edge is the one following the drive.
  task automatic step(input int sel, input logic [3:0] req, input logic [3:0] exp_g, input string tag);
    case (sel)
      0:       bus4.requests = req;
      1:       busb.requests = req;
      default: bus3.requests = req[2:0];
    endcase
    exp_q.push_back({2'(sel), exp_g});
`ifdef RR_ARB_REGISTERED_GRANTS_EN
    @(posedge clk); #1;
    check_pop(tag);
`else
    #3;
    check_pop(tag);
    @(posedge clk); #1;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus4.requests = '0;
    busb.requests = '0;
    bus3.requests = '0;
    #2;
    check("rst_grants", bus4.grants, 4'b0000);
    check("rst_valid", {3'b0, bus4.grant_valid}, 4'b0000);
    check("rst_idx", {2'b0, bus4.grant_idx}, 4'b0000);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // 1: full contention rotates through all requesters
    do_reset();
`ifdef RR_ARB_REGISTERED_GRANTS_EN
    bus4.requests = 4'b1111;
    #2;
    check("reg_first_cycle", bus4.grants, 4'b0000);
`endif
    for (int k = 0; k < 8; k++) step(0, 4'b1111, 4'b0001 << (k % 4), "s1_rotate");

    // 2: sparse requests, then a lone requester
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 4'b1010, (k % 2 == 0) ? 4'b0010 : 4'b1000, "s2_sparse");
    for (int k = 0; k < 3; k++) step(0, 4'b0100, 4'b0100, "s2_lone");

    // 3: pointer survives idle cycles
    do_reset();
    step(0, 4'b1111, 4'b0001, "s3_first");
    step(0, 4'b0000, 4'b0000, "s3_idle");
    step(0, 4'b0000, 4'b0000, "s3_idle");
    step(0, 4'b1111, 4'b0010, "s3_resume");

    // 4: burst hold with MAX_BURST = 3, mid-burst drop, saturation
    do_reset();
    for (int k = 0; k < 9; k++) step(1, 4'b0011, (k / 3 == 1) ? 4'b0010 : 4'b0001, "s4_burst");
    step(1, 4'b0011, 4'b0010, "s4_burst_start");
    step(1, 4'b0001, 4'b0001, "s4_drop");
    for (int k = 0; k < 5; k++) step(1, 4'b0001, 4'b0001, "s4_saturate");

    // 5a: async reset while a grant is live
    do_reset();
    step(0, 4'b1111, 4'b0001, "s5_pre");
    step(0, 4'b1111, 4'b0010, "s5_pre");
    bus4.requests = 4'b1111;
`ifdef RR_ARB_REGISTERED_GRANTS_EN
    @(posedge clk); #1;
`else
    #2;
`endif
    check("s5_live", bus4.grants, 4'b0100);
    rst = 1'b1;
    #1;
    check("s5_async_grants", bus4.grants, 4'b0000);
    check("s5_async_valid", {3'b0, bus4.grant_valid}, 4'b0000);
    check("s5_async_idx", {2'b0, bus4.grant_idx}, 4'b0000);
    bus4.requests = 4'b0000;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step(0, 4'b1111, 4'b0001, "s5_after_rst");

    // 5b: non-power-of-two wrap
    do_reset();
    for (int k = 0; k < 4; k++) step(2, 4'b0111, 4'b0001 << (k % 3), "s5_wrap3");

    // Randomised lone requester on the 4x1 instance: always granted
    for (int k = 0; k < 6; k++) begin
      logic [3:0] one;
      one = 4'b0001 << $urandom_range(3, 0);
      step(0, one, one, "rand_lone");
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL leftover_queue: observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
